// File: rtl/spike_rate_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : spike_rate_decoder
//  Purpose  : Converts one-bit spike trains back into per-channel rate values.
//             Rising edges on each channel are counted over a programmable
//             window of clock cycles. At window end the counts are latched
//             into a snapshot, which is then streamed out one channel per beat
//             over a valid/ready interface.
//
//  Parameters
//    N_CH   number of spike channels (bit 0 of spike_in is channel 0)
//    CNT_W  width of each per-channel spike counter
//    WIN_W  width of the window-length counter
//
//  Ports
//    clk        in   clock, all logic on the rising edge
//    rst_n      in   asynchronous active-low reset
//    enable     in   counting enable; when low, window and counters clear
//    win_len    in   window length in cycles; 0 stops windows from closing
//    spike_in   in   spike levels from the neurons
//    out_valid  out  a snapshot beat is presented
//    out_ready  in   consumer accepts the current beat
//    out_ch     out  channel index of the current beat
//    out_count  out  spike count of out_ch in the snapshot
//    out_last   out  current beat is for channel N_CH-1
//    overrun    out  sticky: a completed window's snapshot was dropped
//
//  Build option
//    SPIKE_DEC_SAT_EN  when defined, counters and snapshot values saturate
//                      at 2^CNT_W-1; otherwise they wrap modulo 2^CNT_W.
//
//  Revision : 1.0  initial release
// ============================================================================
module spike_rate_decoder #(
    parameter int N_CH  = 6,
    parameter int CNT_W = 8,
    parameter int WIN_W = 16,
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIN_W-1:0] win_len,
    input  logic [N_CH-1:0]  spike_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CH_W-1:0]  out_ch,
    output logic [CNT_W-1:0] out_count,
    output logic             out_last,
    output logic             overrun
);

    localparam logic [WIN_W-1:0] c_win_one = WIN_W'(1);
    localparam logic [CH_W-1:0]  c_ch_one  = CH_W'(1);
    localparam logic [CH_W-1:0]  c_last_ch = CH_W'(N_CH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;

    logic [N_CH-1:0]            r_prev;
    logic [N_CH-1:0]            w_edge;

    logic [WIN_W-1:0]           r_win;
    logic                       w_run;
    logic                       w_term;

    logic [N_CH-1:0][CNT_W-1:0] r_cnt;
    logic [N_CH-1:0][CNT_W-1:0] w_cnt_inc;
    logic [N_CH-1:0][CNT_W-1:0] r_snap;

    logic [CH_W-1:0]            r_ch;
    logic [CH_W-1:0]            w_ch_nxt;
    logic                       w_load;
    logic                       w_ovr_set;
    logic                       r_overrun;
    logic                       w_hs;
    logic                       w_last_beat;

    // ------------------------------------------------------------------
    // Edge detection. The previous level is tracked regardless of enable
    // so that a level already high when counting starts is not seen as
    // a fresh edge.
    // ------------------------------------------------------------------
    assign w_edge = spike_in & ~r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '0;
        end else begin
            r_prev <= spike_in;
        end
    end

    // ------------------------------------------------------------------
    // Window counter. A shortened win_len below the current count is not
    // caught until the counter wraps through 2^WIN_W back to win_len-1.
    // ------------------------------------------------------------------
    assign w_run  = enable & (win_len != '0);
    assign w_term = w_run & (r_win == (win_len - c_win_one));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win <= '0;
        end else if (!enable) begin
            r_win <= '0;
        end else if (w_run) begin
            r_win <= w_term ? '0 : (r_win + c_win_one);
        end
    end

    // ------------------------------------------------------------------
    // Per-channel count plus this cycle's edge. The same value feeds the
    // running counter and the snapshot, so an edge landing on the
    // terminal cycle belongs to the window that is closing.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch_inc
`ifdef SPIKE_DEC_SAT_EN
        assign w_cnt_inc[gi] = (&r_cnt[gi]) ? r_cnt[gi]
                                            : (r_cnt[gi] + CNT_W'(w_edge[gi]));
`else
        assign w_cnt_inc[gi] = r_cnt[gi] + CNT_W'(w_edge[gi]);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!enable || w_term) begin
            r_cnt <= '0;
        end else if (w_run) begin
            r_cnt <= w_cnt_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap <= '0;
        end else if (w_load) begin
            r_snap <= w_cnt_inc;
        end
    end

    // ------------------------------------------------------------------
    // Output FSM. The snapshot is only reloaded from IDLE or on the very
    // cycle the last beat is accepted; any other terminal cycle during
    // SEND loses its snapshot and raises the sticky overrun flag.
    // ------------------------------------------------------------------
    assign w_hs        = (r_state == S_SEND) & out_ready;
    assign w_last_beat = w_hs & (r_ch == c_last_ch);

    always_comb begin
        w_state_nxt = r_state;
        w_ch_nxt    = r_ch;
        w_load      = 1'b0;
        w_ovr_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_term) begin
                    w_load      = 1'b1;
                    w_ch_nxt    = '0;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (w_last_beat) begin
                    // Channel index returns to 0 whether a new snapshot
                    // follows back-to-back or the FSM goes idle.
                    w_ch_nxt = '0;
                    if (w_term) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    if (w_hs) begin
                        w_ch_nxt = r_ch + c_ch_one;
                    end
                    if (w_term) begin
                        w_ovr_set = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_ch_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ch      <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ch      <= w_ch_nxt;
            r_overrun <= r_overrun | w_ovr_set;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. The count is forced to zero outside SEND so the bus is
    // quiet while idle; r_ch is already 0 whenever the FSM is idle.
    // ------------------------------------------------------------------
    assign out_valid = (r_state == S_SEND);
    assign out_ch    = r_ch;
    assign out_count = out_valid ? r_snap[r_ch] : '0;
    assign out_last  = out_valid & (r_ch == c_last_ch);
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: doc/spike_rate_decoder.md
# spike_rate_decoder

Receiver for the one-bit spike outputs of the LIF neuron array. It counts rising edges per spike channel over a programmable window of clock cycles and latches the counts into a snapshot at window end. It then streams the snapshot out one channel per beat over a valid/ready interface. It sits downstream of the five presynaptic neurons and the postsynaptic neuron, turning spike trains back into rate values for the host or for the STDP weight logic.

## Interface
Parameters:
- N_CH, 6, number of spike channels; bit 0 is channel 0.
- CNT_W, 8, width of each per-channel spike counter.
- WIN_W, 16, width of the window-length counter.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- enable  input  1  counting enable.
- win_len  input  WIN_W  window length in cycles; 0 disables window closing.
- spike_in  input  N_CH  spike levels from the neurons.
- out_valid  output  1  a beat is presented.
- out_ready  input  1  the consumer accepts the beat.
- out_ch  output  $clog2(N_CH)  channel index of the current beat.
- out_count  output  CNT_W  spike count for out_ch.
- out_last  output  1  the beat is for channel N_CH-1.
- overrun  output  1  sticky flag: a snapshot was dropped.

## Operation
- Edge detect: edge[i] = spike_in[i] & ~prev[i]. prev is registered every cycle, including when enable=0. A spike held high for several cycles counts once.
- When enable=1 and win_len!=0:
  - The window counter runs 0..win_len-1.
  - Each edge increments cnt[i].
- Terminal cycle: the window counter equals win_len-1.
  - Snapshot[i] = cnt[i] + edge[i], so an edge on the terminal cycle is included.
  - cnt[i] clears to 0 and the window counter wraps to 0.
- When enable=0: the window counter and all cnt[i] clear to 0 and hold. The output FSM keeps running, so a pending snapshot still drains.
- win_len changes take effect in the current window. If the window counter is already ≥ win_len, the window closes at the next wrap of the counter (2^WIN_W).
- Output FSM, two states:
  - IDLE to SEND on a terminal cycle: snapshot loaded, ch=0.
  - SEND: out_valid=1, out_ch=ch, out_count=snapshot[ch].
  - SEND, on out_valid&out_ready with ch<N_CH-1: ch increments.
  - SEND, on out_valid&out_ready with ch=N_CH-1: go to IDLE.
- Overrun:
  - A terminal cycle while in SEND drops the new snapshot. The old snapshot is not modified, and overrun is set (sticky until reset).
  - Exception: a terminal cycle coincides with the handshake of the last beat. The new snapshot is loaded, the FSM stays in SEND with ch=0, and overrun is not set.
- Outputs are stable while out_valid=1 and out_ready=0.

## Timing
- Reset values: out_valid=0, out_ch=0, out_count=0, out_last=0, overrun=0, FSM=IDLE. All counters, prev and the snapshot are 0.
- Latency: an edge at spike_in in cycle t appears in cnt[i] at t+1.
- A terminal cycle t gives out_valid=1 at t+1 with channel 0.
- Throughput: one beat per cycle while out_ready=1. A full snapshot drains in N_CH cycles, so win_len < N_CH with out_ready held high always overruns.
- Reset asserted mid-window or mid-SEND clears everything immediately. No partial beat is completed.

## Configuration
- SPIKE_DEC_SAT_EN defined: cnt[i] and snapshot values saturate at 2^CNT_W-1.
- SPIKE_DEC_SAT_EN undefined: counts wrap modulo 2^CNT_W.

## Test plan
- Single burst: win_len=10, enable=1, out_ready=1. Pulse channel 2 three times with 1-cycle pulses, 2 cycles apart. Required: 6 beats; ch2 count=3, all others 0; out_last only on ch5.
- Held level: hold channel 0 high for 8 cycles inside a 10-cycle window. Required: count=1. A pulse on the terminal cycle itself is counted in the same window.
- Backpressure: out_ready=0 for 20 cycles after out_valid rises. Required: out_ch=0 and out_count stable throughout, and overrun set if a window ends within those cycles (win_len=10).
- Saturation: CNT_W=4, 20 edges in a window. Required: count=15 with SPIKE_DEC_SAT_EN defined, and count=4 without it.
- Boundary handshake: choose win_len so the terminal cycle coincides with the last beat handshake (win_len=6, out_ready=1). Required: back-to-back snapshots and overrun=0.
- Reset and enable: assert rst_n=0 mid-SEND. Required: all outputs 0 next edge and the FSM in IDLE. Also, with enable=0, any spike input yields no snapshot and no out_valid.
